// File: rtl/freq_double_mode_if.sv
// freq_double_mode_if: enable in, composite I/Q sample and valid level out.
// master is the DDS source side, slave is the parent that enables and consumes it.
interface freq_double_mode_if;
  logic        MODULE_ENA;
  logic [31:0] DDS_OUT;
  logic        DDS_DATA_VALID;

  modport master (
    input  MODULE_ENA,
    output DDS_OUT,
    output DDS_DATA_VALID
  );

  modport slave (
    output MODULE_ENA,
    input  DDS_OUT,
    input  DDS_DATA_VALID
  );
endinterface

// File: rtl/freq_double_mode.sv
// freq_double_mode: dual-tone DDS for the "double" shaping mode.
// Two phase accumulators share a quarter-wave sine ROM; halved samples are summed.
module freq_double_mode #(
  parameter logic [31:0] FTW_A = 32'd42_949_673,
  parameter logic [31:0] FTW_B = 32'd85_899_346
) (
  input logic                GCLK,
  input logic                reset,
  freq_double_mode_if.master dds
);

  function automatic logic [15:0] qwave(input int k);
    real a;
    a = 32767.0 * $sin(6.283185307179586 * ($itor(k) + 0.5) / 1024.0);
    return 16'($rtoi(a + 0.5));
  endfunction

  logic signed [15:0] rom [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [15:0] QK = qwave(k);
    assign rom[k] = QK;
  end

  // odd quadrants mirror the index (255-i == ~i), upper half negates
  function automatic logic signed [15:0] lut(input logic [9:0] p);
    logic [7:0]         idx;
    logic signed [15:0] mag;
    idx = p[8] ? ~p[7:0] : p[7:0];
    mag = rom[idx];
    return p[9] ? -mag : mag;
  endfunction

  logic [31:0]        acc_a_q, acc_a_d;
  logic [31:0]        acc_b_q, acc_b_d;
  logic [9:0]         ph_a_q, ph_a_d;
  logic [9:0]         ph_b_q, ph_b_d;
  logic signed [15:0] sin_a_q, sin_a_d;
  logic signed [15:0] cos_a_q, cos_a_d;
  logic signed [15:0] sin_b_q, sin_b_d;
  logic signed [15:0] cos_b_q, cos_b_d;
  logic               v0_q, v0_d;
  logic               v1_q, v1_d;
  logic [31:0]        out_q, out_d;
  logic               vld_q, vld_d;
  logic signed [15:0] q_sum;
  logic signed [15:0] i_sum;

  always_comb begin
    acc_a_d = '0;
    acc_b_d = '0;
    ph_a_d  = '0;
    ph_b_d  = '0;
    sin_a_d = '0;
    cos_a_d = '0;
    sin_b_d = '0;
    cos_b_d = '0;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    out_d   = '0;
    vld_d   = 1'b0;
    q_sum   = (sin_a_q >>> 1) + (sin_b_q >>> 1);
    i_sum   = (cos_a_q >>> 1) + (cos_b_q >>> 1);
    if (dds.MODULE_ENA) begin
      acc_a_d = acc_a_q + FTW_A;
      acc_b_d = acc_b_q + FTW_B;
      ph_a_d  = acc_a_q[31:22];
      ph_b_d  = acc_b_q[31:22];
      v0_d    = 1'b1;
      v1_d    = v0_q;
      vld_d   = v1_q;
      // gate on stage valid so the output is zero until the first real sample
      if (v0_q) begin
        sin_a_d = lut(ph_a_q);
        cos_a_d = lut(ph_a_q + 10'd256);
        sin_b_d = lut(ph_b_q);
        cos_b_d = lut(ph_b_q + 10'd256);
      end
      if (v1_q) begin
        out_d = {i_sum, q_sum};
      end
    end
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      ph_a_q  <= '0;
      ph_b_q  <= '0;
      sin_a_q <= '0;
      cos_a_q <= '0;
      sin_b_q <= '0;
      cos_b_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      ph_a_q  <= ph_a_d;
      ph_b_q  <= ph_b_d;
      sin_a_q <= sin_a_d;
      cos_a_q <= cos_a_d;
      sin_b_q <= sin_b_d;
      cos_b_q <= cos_b_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign dds.DDS_OUT        = out_q;
  assign dds.DDS_DATA_VALID = vld_q;

endmodule

// File: tb/tb_freq_double_mode.sv
// tb_freq_double_mode: directed checks of start-up, disable, wrap, period
// and asynchronous reset on three differently tuned instances.
module tb_freq_double_mode;

  localparam logic [31:0] START = 32'h7FFE_0064;
  localparam logic [31:0] ODD_W = 32'h8000_FF9A;

  logic GCLK;
  logic reset;
  int   total;
  int   bad;

  freq_double_mode_if if_d ();
  freq_double_mode_if if_w ();
  freq_double_mode_if if_p ();

  freq_double_mode u_def (
    .GCLK  (GCLK),
    .reset (reset),
    .dds   (if_d)
  );

  freq_double_mode #(
    .FTW_A (32'h8000_0000),
    .FTW_B (32'h8000_0000)
  ) u_wrap (
    .GCLK  (GCLK),
    .reset (reset),
    .dds   (if_w)
  );

  freq_double_mode #(
    .FTW_A (32'h0040_0000),
    .FTW_B (32'h0040_0000)
  ) u_per (
    .GCLK  (GCLK),
    .reset (reset),
    .dds   (if_p)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  task automatic test_reset();
    reset = 1'b0;
    if_d.MODULE_ENA = 1'b1;
    repeat (3) @(negedge GCLK);
    total++;
    if (if_d.DDS_OUT !== 32'h0 || if_d.DDS_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold out=%h vld=%b want 00000000/0",
               if_d.DDS_OUT, if_d.DDS_DATA_VALID);
    end
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge GCLK);
      total++;
      if (e < 3 && (if_d.DDS_DATA_VALID !== 1'b0 || if_d.DDS_OUT !== 32'h0)) begin
        bad++;
        $display("FAIL reset_release_e%0d out=%h vld=%b want 00000000/0",
                 e, if_d.DDS_OUT, if_d.DDS_DATA_VALID);
      end
      if (e == 3 && (if_d.DDS_DATA_VALID !== 1'b1 || if_d.DDS_OUT !== START)) begin
        bad++;
        $display("FAIL reset_release_e3 out=%h vld=%b want %h/1",
                 if_d.DDS_OUT, if_d.DDS_DATA_VALID, START);
      end
    end
  endtask

  task automatic test_startup();
    if_d.MODULE_ENA = 1'b0;
    repeat (2) @(negedge GCLK);
    total++;
    if (if_d.DDS_OUT !== 32'h0 || if_d.DDS_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL startup_idle out=%h vld=%b want 00000000/0",
               if_d.DDS_OUT, if_d.DDS_DATA_VALID);
    end
    if_d.MODULE_ENA = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge GCLK);
      total++;
      if (e < 3 && if_d.DDS_DATA_VALID !== 1'b0) begin
        bad++;
        $display("FAIL startup_e%0d vld=%b want 0", e, if_d.DDS_DATA_VALID);
      end
      if (e == 3 && (if_d.DDS_DATA_VALID !== 1'b1 || if_d.DDS_OUT !== START)) begin
        bad++;
        $display("FAIL startup_e3 out=%h vld=%b want %h/1",
                 if_d.DDS_OUT, if_d.DDS_DATA_VALID, START);
      end
    end
  endtask

  task automatic test_disable();
    repeat (5) @(negedge GCLK);
    if_d.MODULE_ENA = 1'b0;
    @(negedge GCLK);
    total++;
    if (if_d.DDS_OUT !== 32'h0 || if_d.DDS_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL disable out=%h vld=%b want 00000000/0",
               if_d.DDS_OUT, if_d.DDS_DATA_VALID);
    end
    if_d.MODULE_ENA = 1'b1;
    repeat (2) @(negedge GCLK);
    total++;
    if (if_d.DDS_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reenable_e2 vld=%b want 0", if_d.DDS_DATA_VALID);
    end
    @(negedge GCLK);
    total++;
    if (if_d.DDS_DATA_VALID !== 1'b1 || if_d.DDS_OUT !== START) begin
      bad++;
      $display("FAIL reenable_e3 out=%h vld=%b want %h/1",
               if_d.DDS_OUT, if_d.DDS_DATA_VALID, START);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    if_w.MODULE_ENA = 1'b1;
    repeat (3) @(negedge GCLK);
    for (int k = 0; k < 8; k++) begin
      want = (k % 2 == 0) ? START : ODD_W;
      total++;
      if (if_w.DDS_DATA_VALID !== 1'b1 || if_w.DDS_OUT !== want) begin
        bad++;
        $display("FAIL wrap_s%0d out=%h vld=%b want %h/1",
                 k, if_w.DDS_OUT, if_w.DDS_DATA_VALID, want);
      end
      @(negedge GCLK);
    end
    if_w.MODULE_ENA = 1'b0;
  endtask

  task automatic test_period();
    logic signed [15:0] q_s [1030];
    logic signed [15:0] i_s [1030];
    logic signed [15:0] mx;
    logic signed [15:0] mn;
    int n;
    int rep_bad;
    if_p.MODULE_ENA = 1'b1;
    n = 0;
    while (if_p.DDS_DATA_VALID !== 1'b1 && n < 10) begin
      @(negedge GCLK);
      n++;
    end
    total++;
    if (if_p.DDS_DATA_VALID !== 1'b1) begin
      bad++;
      $display("FAIL period_start vld=%b want 1 within 10 edges",
               if_p.DDS_DATA_VALID);
    end else begin
      for (int k = 0; k < 1030; k++) begin
        q_s[k] = if_p.DDS_OUT[15:0];
        i_s[k] = if_p.DDS_OUT[31:16];
        @(negedge GCLK);
      end
      total++;
      if (n !== 3) begin
        bad++;
        $display("FAIL period_latency edges=%0d want 3", n);
      end
      total++;
      if (q_s[0] !== 16'sd100 || i_s[0] !== 16'sd32766) begin
        bad++;
        $display("FAIL period_s0 q=%0d i=%0d want 100/32766", q_s[0], i_s[0]);
      end
      total++;
      if (q_s[1] !== 16'sd302) begin
        bad++;
        $display("FAIL period_s1 q=%0d want 302", q_s[1]);
      end
      total++;
      if (q_s[255] !== 16'sd32766 || q_s[256] !== 16'sd32766) begin
        bad++;
        $display("FAIL period_peak q255=%0d q256=%0d want 32766/32766",
                 q_s[255], q_s[256]);
      end
      total++;
      if (q_s[512] !== -16'sd102 || i_s[256] !== -16'sd102) begin
        bad++;
        $display("FAIL period_half q512=%0d i256=%0d want -102/-102",
                 q_s[512], i_s[256]);
      end
      total++;
      if (q_s[768] !== -16'sd32768) begin
        bad++;
        $display("FAIL period_trough q768=%0d want -32768", q_s[768]);
      end
      mx = q_s[0];
      mn = q_s[0];
      for (int k = 1; k < 1024; k++) begin
        if (q_s[k] > mx) mx = q_s[k];
        if (q_s[k] < mn) mn = q_s[k];
      end
      total++;
      if (mx !== 16'sd32766 || mn !== -16'sd32768) begin
        bad++;
        $display("FAIL period_extremes max=%0d min=%0d want 32766/-32768", mx, mn);
      end
      rep_bad = 0;
      for (int k = 0; k < 6; k++) begin
        if (q_s[k + 1024] !== q_s[k]) rep_bad++;
      end
      total++;
      if (rep_bad !== 0 || q_s[1024] !== 16'sd100) begin
        bad++;
        $display("FAIL period_repeat diffs=%0d q1024=%0d want 0/100",
                 rep_bad, q_s[1024]);
      end
    end
    if_p.MODULE_ENA = 1'b0;
  endtask

  task automatic test_async_reset();
    if_d.MODULE_ENA = 1'b1;
    repeat (4) @(negedge GCLK);
    total++;
    if (if_d.DDS_DATA_VALID !== 1'b1) begin
      bad++;
      $display("FAIL async_pre vld=%b want 1", if_d.DDS_DATA_VALID);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (if_d.DDS_OUT !== 32'h0 || if_d.DDS_DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL async_clear out=%h vld=%b want 00000000/0",
               if_d.DDS_OUT, if_d.DDS_DATA_VALID);
    end
    @(negedge GCLK);
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge GCLK);
      total++;
      if (e < 3 && if_d.DDS_DATA_VALID !== 1'b0) begin
        bad++;
        $display("FAIL async_release_e%0d vld=%b want 0", e, if_d.DDS_DATA_VALID);
      end
      if (e == 3 && (if_d.DDS_DATA_VALID !== 1'b1 || if_d.DDS_OUT !== START)) begin
        bad++;
        $display("FAIL async_release_e3 out=%h vld=%b want %h/1",
                 if_d.DDS_OUT, if_d.DDS_DATA_VALID, START);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    if_d.MODULE_ENA = 1'b0;
    if_w.MODULE_ENA = 1'b0;
    if_p.MODULE_ENA = 1'b0;
    #2;
    test_reset();
    test_startup();
    test_disable();
    test_wrap();
    test_period();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
